// File: rtl/frankie_pkg.sv
// rtl/frankie_pkg.sv - shared widths, instruction field positions and fetch-state encoding
// Contents:
//   ADDR_W_DEF, INST_W_DEF, TIMEOUT_DEF  default widths and wait limit
//   OPC_MSB/OPC_LSB/FLAG_BIT/IMM_MSB     instruction field positions
//   fetch_state_t, ST_IDLE/ST_REQ/ST_WAIT fetch FSM encoding
package frankie_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INST_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int FLAG_BIT = 10;
    localparam int IMM_MSB  = 9;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_WAIT = 2'd2;

endpackage

// File: rtl/ir_decode.sv
// rtl/ir_decode.sv - combinational field extraction from an instruction word
// Ports:
//   ir        in   instruction word
//   opcode    out  ir[15:11]
//   flagbit   out  ir[10]
//   imm_sext  out  ir[9:0] sign-extended to ADDR_W
module ir_decode
    import frankie_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic [INST_W-1:0] ir,
    output logic [4:0]        opcode,
    output logic              flagbit,
    output logic [ADDR_W-1:0] imm_sext
);

    assign opcode   = ir[OPC_MSB:OPC_LSB];
    assign flagbit  = ir[FLAG_BIT];
    // Replicate the immediate's top bit across the upper address bits.
    assign imm_sext = {{(ADDR_W - IMM_MSB - 1){ir[IMM_MSB]}}, ir[IMM_MSB:0]};

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC/IR owner running the request/grant/response fetch handshake
// Ports:
//   CLK, Reset             clock, asynchronous active-high reset
//   fetch_start            one-cycle fetch request (ignored while busy)
//   pc_load, pc_in         PC redirect; wins over the fetch increment
//   mem_req, mem_addr      read request and its address
//   mem_gnt                request accepted
//   mem_rvalid, mem_rdata  read response
//   OPCODE, flagbit, imm_sext  decoded IR fields
//   pc_out, pc_plus1       current PC and PC+1
//   inst_valid             IR holds a freshly fetched instruction
//   busy                   fetch in progress (REQ or WAIT)
//   fetch_err              sticky response timeout
module inst_fetch_unit
    import frankie_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INST_W  = INST_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [4:0]        OPCODE,
    output logic              flagbit,
    output logic [ADDR_W-1:0] imm_sext,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              inst_valid,
    output logic              busy,
    output logic              fetch_err
);

    // Last WAIT cycle index: the timeout fires on the TIMEOUT-th WAIT cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic [INST_W-1:0] ir;
    logic [7:0]        wait_cnt;
    logic              accept_data;

    // Response is only taken in WAIT, so rvalid alongside the grant is dropped.
    assign accept_data = (state == ST_WAIT) && mem_rvalid;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            pc         <= '0;
            req_addr   <= '0;
            ir         <= '0;
            wait_cnt   <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        state      <= ST_REQ;
                        inst_valid <= 1'b0;
                        // Address is captured here so a redirect during REQ
                        // cannot disturb the outstanding request.
                        req_addr   <= pc_load ? pc_in : pc;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state      <= ST_IDLE;
                        ir         <= mem_rdata;
                        inst_valid <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_IDLE;
                        fetch_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (pc_load) begin
                pc <= pc_in;
            end else if (accept_data) begin
                pc <= pc_plus1;
            end
        end
    end

    assign mem_req  = (state == ST_REQ);
    assign mem_addr = req_addr;
    assign busy     = (state != ST_IDLE);
    assign pc_out   = pc;
    assign pc_plus1 = pc + ADDR_W'(1);

    ir_decode #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_ir_decode (
        .ir       (ir),
        .opcode   (OPCODE),
        .flagbit  (flagbit),
        .imm_sext (imm_sext)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [4:0]  OPCODE;
    logic        flagbit;
    logic [15:0] imm_sext;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;
    logic        inst_valid;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    inst_fetch_unit #(.ADDR_W(16), .INST_W(16), .TIMEOUT(15)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .OPCODE      (OPCODE),
        .flagbit     (flagbit),
        .imm_sext    (imm_sext),
        .pc_out      (pc_out),
        .pc_plus1    (pc_plus1),
        .inst_valid  (inst_valid),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One fetch: grant on the first REQ cycle, response on the first WAIT cycle.
    task automatic do_fetch(input logic [15:0] data, input logic ld, input logic [15:0] ld_val,
                            output logic [15:0] req_a);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mem_gnt = 1'b1;
        req_a = mem_addr;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = data;
        pc_load = ld;
        pc_in = ld_val;
        tick();
        mem_rvalid = 1'b0;
        pc_load = 1'b0;
    endtask

    logic [15:0] ra;
    int bad;
    int req_cycles;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        chk("rst_opc", {OPCODE, flagbit, imm_sext}, 32'h0);
        Reset = 1'b0;
        tick();

        // Basic fetch with latency check; rvalid alongside grant must be dropped
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t1_req", mem_req, 1'b1);
        chk("t1_addr", mem_addr, 16'h0000);
        chk("t1_busy", busy, 1'b1);
        chk("t1_valid_c1", inst_valid, 1'b0);
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_gnt = 1'b0;
        chk("t1_req_wait", mem_req, 1'b0);
        chk("t1_valid_c2", inst_valid, 1'b0);
        chk("t1_busy_wait", busy, 1'b1);
        mem_rdata = 16'h0405;
        tick();
        mem_rvalid = 1'b0;
        chk("t1_valid_c3", inst_valid, 1'b1);
        chk("t1_opc", OPCODE, 5'b00000);
        chk("t1_flag", flagbit, 1'b1);
        chk("t1_imm", imm_sext, 16'h0005);
        chk("t1_pc", pc_out, 16'h0001);
        chk("t1_pc1", pc_plus1, 16'h0002);
        chk("t1_busy_done", busy, 1'b0);
        tick();
        chk("t1_valid_hold", inst_valid, 1'b1);

        // Negative immediate and PC wrap
        pc_load = 1'b1;
        pc_in = 16'hFFFF;
        tick();
        pc_load = 1'b0;
        chk("t2_pc_loaded", pc_out, 16'hFFFF);
        chk("t2_pc1_wrap", pc_plus1, 16'h0000);
        do_fetch(16'h3A00, 1'b0, 16'h0000, ra);
        chk("t2_addr", ra, 16'hFFFF);
        chk("t2_opc", OPCODE, 5'b00111);
        chk("t2_flag", flagbit, 1'b0);
        chk("t2_imm", imm_sext, 16'hFE00);
        chk("t2_pc_wrap", pc_out, 16'h0000);

        // pc_load together with the accepted response
        do_fetch(16'h8123, 1'b1, 16'h0040, ra);
        chk("t3_pc", pc_out, 16'h0040);
        chk("t3_opc", OPCODE, 5'b10000);
        chk("t3_imm", imm_sext, 16'h0123);
        do_fetch(16'h07FF, 1'b0, 16'h0000, ra);
        chk("t3_next_addr", ra, 16'h0040);
        chk("t3_imm_neg", imm_sext, 16'hFFFF);
        chk("t3_flag", flagbit, 1'b1);
        chk("t3_pc_inc", pc_out, 16'h0041);

        // Timeout after exactly 15 WAIT cycles
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (fetch_err !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        chk("t4_no_early_err", bad, 0);
        chk("t4_err", fetch_err, 1'b1);
        chk("t4_idle", busy, 1'b0);
        chk("t4_valid", inst_valid, 1'b0);
        chk("t4_ir_kept", {OPCODE, flagbit, imm_sext}, {11'h0, 5'b00000, 1'b1, 16'hFFFF});
        chk("t4_pc_kept", pc_out, 16'h0041);
        do_fetch(16'h1000, 1'b0, 16'h0000, ra);
        chk("t4_err_sticky", fetch_err, 1'b1);
        chk("t4_valid_after", inst_valid, 1'b1);
        chk("t4_opc_after", OPCODE, 5'b00010);
        chk("t4_pc_after", pc_out, 16'h0042);

        // Long grant stall, ignored fetch_start, pc_load during REQ
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        bad = 0;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (mem_addr !== 16'h0042 || fetch_err !== 1'b1 || busy !== 1'b1) bad++;
            fetch_start = (i == 10);
            pc_load = (i == 20);
            pc_in = 16'h0100;
            tick();
        end
        fetch_start = 1'b0;
        pc_load = 1'b0;
        chk("t5_req_cycles", req_cycles, 40);
        chk("t5_stable", bad, 0);
        chk("t5_pc_redirect", pc_out, 16'h0100);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 16'h2ABC;
        tick();
        mem_rvalid = 1'b0;
        chk("t5_pc", pc_out, 16'h0101);
        chk("t5_imm", imm_sext, 16'hFEBC);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        chk("t5_single_req", bad, 0);

        // Asynchronous reset in WAIT, then a stray response
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("t6_in_wait", busy, 1'b1);
        #2 Reset = 1'b1;
        #1;
        chk("t6_req", mem_req, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_pc", pc_out, 16'h0000);
        tick();
        Reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("t6_ir_clear", {OPCODE, flagbit, imm_sext}, 32'h0);
        chk("t6_valid", inst_valid, 1'b0);
        chk("t6_err_clear", fetch_err, 1'b0);
        chk("t6_pc_after", pc_out, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Fetch stage that sits directly upstream of the Frankie control unit. It owns the PC and the instruction register (IR) and runs a request/grant/response handshake with instruction memory. It presents the decoded OPCODE, flagbit and immediate fields that the control unit consumes. The control unit triggers a fetch, waits for inst_valid, and may redirect the PC through pc_load for jumps and calls.

Parameters:
ADDR_W, 16, PC and memory address width
INST_W, 16, instruction width; the fields are [15:11] opcode, [10] flagbit, [9:0] immediate
TIMEOUT, 15, maximum number of WAIT cycles before a fetch error; range 1..255

Ports:
CLK  input  1  clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-high reset
fetch_start  input  1  one-cycle request from the control unit's Fetch state
pc_load  input  1  load the PC from pc_in (jump, call, return)
pc_in  input  ADDR_W  target PC value
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  read address; equals PC while mem_req is high
mem_gnt  input  1  memory accepted the request
mem_rvalid  input  1  read data valid
mem_rdata  input  INST_W  instruction word
OPCODE  output  5  IR[15:11]
flagbit  output  1  IR[10]
imm_sext  output  ADDR_W  IR[9:0] sign-extended to ADDR_W
pc_out  output  ADDR_W  current PC
pc_plus1  output  ADDR_W  PC+1, used as the return address for JFNC
inst_valid  output  1  IR holds a freshly fetched instruction
busy  output  1  a fetch is in progress
fetch_err  output  1  sticky timeout flag

Behaviour:
- Reset values (asynchronous): state=IDLE, PC=0, IR=0, mem_req=0, inst_valid=0, busy=0, fetch_err=0, wait counter=0. A Reset asserted mid-fetch drops mem_req immediately. A mem_rvalid arriving after Reset is ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: when fetch_start=1, go to REQ; inst_valid clears at this edge.
  - REQ: mem_req=1, mem_addr=PC. When mem_gnt=1, go to WAIT and clear the counter. Otherwise hold in REQ with no timeout.
  - WAIT: mem_req=0, counter increments each cycle.
    - When mem_rvalid=1: IR<=mem_rdata, inst_valid<=1, PC<=PC+1, go to IDLE.
    - When the counter reaches TIMEOUT with no rvalid: fetch_err<=1, IR unchanged, go to IDLE.
- busy=1 in REQ and WAIT. fetch_start while busy is ignored and is not queued.
- mem_rvalid in the same cycle as mem_gnt is not accepted. Data is accepted only in WAIT, so minimum latency from fetch_start to inst_valid is 3 cycles.
- inst_valid stays high until the next accepted fetch_start.
- PC update priority: pc_load > fetch increment.
  - pc_load in the same cycle as an accepted rvalid: PC<=pc_in, no increment; IR is still loaded.
  - pc_load while in REQ: the registered mem_addr of the outstanding request does not change. PC<=pc_in, so the next fetch uses the new PC.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000.
- imm_sext replicates IR[9] into the upper bits.
- fetch_err is sticky; only Reset clears it. A fetch that completes after an error still sets inst_valid.
- OPCODE, flagbit and imm_sext are purely combinational from IR and are stable while in IDLE.

Decomposition:
- Shared package frankie_pkg holds:
  - field-position constants OPC_MSB=15, OPC_LSB=11, FLAG_BIT=10, IMM_MSB=9;
  - the fetch-state typedef/encoding (IDLE=0, REQ=1, WAIT=2);
  - the default widths.
- One sub-module, ir_decode: combinational field extraction and sign extension from IR. It is reused later by the disassembler/trace monitor.

Test Plan:
- Reset, then fetch_start; grant in 1 cycle; rvalid the next cycle with 0x0405 -> OPCODE=5'b00000, flagbit=1, imm_sext=0x0005, PC=1, inst_valid high exactly 3 cycles after fetch_start.
- IR=0x3A00 (opcode 00111, flag 0, imm 0x200) -> imm_sext=0xFE00. With PC=0xFFFF, a completed fetch leaves PC=0x0000.
- pc_load with pc_in=0x0040 in the same cycle as rvalid -> PC=0x0040 (not old+1) and IR loaded. The next fetch drives mem_addr=0x0040.
- Grant, then withhold rvalid -> fetch_err=1 after exactly TIMEOUT(15) WAIT cycles, state IDLE, IR unchanged. A subsequent successful fetch leaves fetch_err=1.
- Hold mem_gnt low for 40 cycles -> mem_req held with a stable mem_addr and no error. A fetch_start pulse during busy is ignored, yielding exactly one memory request.
- Assert Reset asynchronously in the middle of WAIT -> mem_req=0, busy=0, PC=0 before the next edge. A later stray rvalid does not load IR.
